// File: rtl/mult_div_unit.sv
// Iterative MIPS-style MULT/MULTU/DIV/DIVU unit; result lands in HI/LO after Data_Width+1 cycles.
// Define MDU_DIV_EN to compile in the restoring divider; otherwise divide requests are ignored.
module mult_div_unit #(
  parameter int Data_Width = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic [1:0]            Op,
  input  logic [Data_Width-1:0] SrcA,
  input  logic [Data_Width-1:0] SrcB,
  output logic                  Busy,
  output logic                  Done,
  output logic [Data_Width-1:0] HI,
  output logic [Data_Width-1:0] LO
);
  localparam int DW = Data_Width;
  localparam int CW = $clog2(Data_Width) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]   cnt;
  logic [2*DW:0]   acc;
  logic [DW-1:0]   opnd;
  logic            sign_a, sign_b;
  logic            accept;
  logic [DW-1:0]   mag_a, mag_b;
  logic [DW-1:0]   ld_opnd, ld_low;
  logic [DW:0]     mul_upper;
  logic [2*DW:0]   step_nxt;
  logic [2*DW-1:0] prod_fix;
  logic [DW-1:0]   hi_nxt, lo_nxt;

  assign mag_a     = (Op[0] & SrcA[DW-1]) ? -SrcA : SrcA;
  assign mag_b     = (Op[0] & SrcB[DW-1]) ? -SrcB : SrcB;
  assign Busy      = (state != IDLE);
  // acc holds {partial product (DW+1), multiplier}; add multiplicand into the top, then shift right
  assign mul_upper = acc[0] ? (acc[2*DW:DW] + {1'b0, opnd}) : acc[2*DW:DW];
  assign prod_fix  = (sign_a ^ sign_b) ? -acc[2*DW-1:0] : acc[2*DW-1:0];

`ifdef MDU_DIV_EN
  logic          is_div, div_zero;
  logic [DW:0]   shifted, diff;
  logic          qbit;
  logic [DW-1:0] quo_fix, rem_fix;

  assign accept  = Start;
  assign ld_opnd = Op[1] ? mag_b : mag_a;
  assign ld_low  = Op[1] ? mag_a : mag_b;
  // acc holds {0, remainder, quotient/dividend}; remainder never exceeds DW bits
  assign shifted = acc[2*DW-1:DW-1];
  assign diff    = shifted - {1'b0, opnd};
  assign qbit    = ~diff[DW];
  assign quo_fix = (sign_a ^ sign_b) ? -acc[DW-1:0] : acc[DW-1:0];
  assign rem_fix = sign_a ? -acc[2*DW-1:DW] : acc[2*DW-1:DW];

  always_comb begin
    step_nxt = {mul_upper, acc[DW-1:0]} >> 1;
    hi_nxt   = prod_fix[2*DW-1:DW];
    lo_nxt   = prod_fix[DW-1:0];
    if (is_div) begin
      step_nxt = {1'b0, (qbit ? diff[DW-1:0] : shifted[DW-1:0]), acc[DW-2:0], qbit};
      hi_nxt   = rem_fix;
      lo_nxt   = div_zero ? '1 : quo_fix;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      is_div   <= 1'b0;
      div_zero <= 1'b0;
    end else if (state == IDLE && accept) begin
      is_div   <= Op[1];
      div_zero <= Op[1] & (SrcB == '0);
    end
  end
`else
  assign accept  = Start & ~Op[1];
  assign ld_opnd = mag_a;
  assign ld_low  = mag_b;

  always_comb begin
    step_nxt = {mul_upper, acc[DW-1:0]} >> 1;
    hi_nxt   = prod_fix[2*DW-1:DW];
    lo_nxt   = prod_fix[DW-1:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (cnt == CW'(1)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      HI     <= '0;
      LO     <= '0;
      Done   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          cnt    <= CW'(DW);
          opnd   <= ld_opnd;
          acc    <= {{(DW+1){1'b0}}, ld_low};
          sign_a <= Op[0] & SrcA[DW-1];
          sign_b <= Op[0] & SrcB[DW-1];
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          acc <= step_nxt;
        end
        FIN: begin
          HI   <= hi_nxt;
          LO   <= lo_nxt;
          Done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random ops against an arithmetic model.
// Honours MDU_DIV_EN: without it, divide requests must be ignored.
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] srcA = '0;
  logic [31:0] srcB = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int nVec = 0;
  int nMis = 0;
  logic [31:0] expHi = '0;
  logic [31:0] expLo = '0;

`ifdef MDU_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  mult_div_unit #(.Data_Width(32)) dut (
    .clk(clk), .reset(reset), .Start(start), .Op(op), .SrcA(srcA), .SrcB(srcB),
    .Busy(busy), .Done(done), .HI(hi), .LO(lo)
  );

  always #5 clk = ~clk;

  // Plain-arithmetic reference: returns {HI, LO}
  function automatic logic [63:0] refModel(input logic [1:0] opIn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (opIn)
      2'b00: return ua * ub;
      2'b01: return sa * sb;
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nVec++;
    assert (obs === expv) else begin
      nMis++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Issues one op and follows it to Done; injectAt >= 0 fires an ignored MULTU 2x2 Start mid-run
  task automatic applyStimulus(input logic [1:0] opIn, input logic [31:0] a, input logic [31:0] b,
                               input int injectAt, input string tag);
    logic [63:0] ref64;
    bit accepted, seen, busyLeak, doneLeak;
    int cyc, busyCnt;
    accepted = !opIn[1] || DivEn;
    ref64 = refModel(opIn, a, b);
    start = 1'b1; op = opIn; srcA = a; srcB = b;
    @(posedge clk); #1;
    start = 1'b0; srcA = $urandom; srcB = $urandom;
    checkOutput({tag, " busy after start"}, 64'(busy), 64'(accepted));
    checkOutput({tag, " done low after start"}, 64'(done), 64'd0);
    if (accepted) begin
      cyc = 0; busyCnt = 0; seen = 1'b0;
      while (!seen && cyc < 40) begin
        if (busy) busyCnt++;
        if (cyc == injectAt) begin
          start = 1'b1; op = 2'b00; srcA = 32'd2; srcB = 32'd2;
        end else begin
          start = 1'b0;
        end
        @(posedge clk); #1;
        cyc++;
        if (done) seen = 1'b1;
      end
      start = 1'b0;
      checkOutput({tag, " done seen"}, 64'(seen), 64'd1);
      checkOutput({tag, " latency"}, 64'(cyc), 64'd33);
      checkOutput({tag, " busy cycles"}, 64'(busyCnt), 64'd33);
      checkOutput({tag, " busy low at done"}, 64'(busy), 64'd0);
      expHi = ref64[63:32];
      expLo = ref64[31:0];
    end else begin
      busyLeak = 1'b0; doneLeak = 1'b0;
      repeat (40) begin
        @(posedge clk); #1;
        if (busy) busyLeak = 1'b1;
        if (done) doneLeak = 1'b1;
      end
      checkOutput({tag, " ignored busy"}, 64'(busyLeak), 64'd0);
      checkOutput({tag, " ignored done"}, 64'(doneLeak), 64'd0);
    end
    checkOutput({tag, " HI"}, 64'(hi), 64'(expHi));
    checkOutput({tag, " LO"}, 64'(lo), 64'(expLo));
  endtask

  initial begin
    bit doneLeak;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    // Reset for two cycles, then idle with Start low
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset HI", 64'(hi), 64'd0);
    checkOutput("reset LO", 64'(lo), 64'd0);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("idle busy", 64'(busy), 64'd0);
    checkOutput("idle done", 64'(done), 64'd0);
    checkOutput("idle HI", 64'(hi), 64'd0);
    checkOutput("idle LO", 64'(lo), 64'd0);

    applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, "multu max");
    applyStimulus(2'b01, 32'hFFFF_FFFD, 32'h0000_0005, 5, "mult -3x5");
    applyStimulus(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, -1, "div -7/2");
    applyStimulus(2'b10, 32'h0000_0007, 32'h0000_0000, -1, "divu 7/0 back-to-back");
    applyStimulus(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, -1, "div overflow");
    applyStimulus(2'b11, 32'h8000_0000, 32'h0000_0000, -1, "div signed by zero");
    applyStimulus(2'b01, 32'h8000_0000, 32'h8000_0000, -1, "mult most-negative");
    applyStimulus(2'b01, 32'h1234_5678, 32'h0000_0000, -1, "mult by zero");

    // Reset in the middle of a MULTU must discard it without a Done
    start = 1'b1; op = 2'b00; srcA = 32'd5; srcB = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    expHi = '0; expLo = '0;
    checkOutput("midreset busy", 64'(busy), 64'd0);
    checkOutput("midreset done", 64'(done), 64'd0);
    checkOutput("midreset HI", 64'(hi), 64'd0);
    checkOutput("midreset LO", 64'(lo), 64'd0);
    doneLeak = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) doneLeak = 1'b1;
    end
    checkOutput("midreset no done", 64'(doneLeak), 64'd0);
    applyStimulus(2'b00, 32'd5, 32'd5, -1, "multu 5x5 after reset");

    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      if ($urandom_range(0, 1) == 1) ra = -ra;
      applyStimulus(rop, ra, rb, (i % 3 == 0) ? int'($urandom_range(1, 20)) : -1, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end
endmodule
